// File: rtl/pipe_issue.sv
// Issue stage: instruction FIFO, RAW hazard bubbles, one issue per clock.
// Ports: clk1/rst_n, in_valid/in_ready/in_instr, halt, flush, issue_valid,
// rs1/rs2/rd/func/addr; issue_cnt/stall_cnt only when PERF_CNT_EN is defined.
module pipe_issue #(
  parameter int DEPTH    = 4,
  parameter int HAZ_DIST = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_instr,
  input  logic        halt,
  input  logic        flush,
  output logic        issue_valid,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr
`ifdef PERF_CNT_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [23:0]         r_mem [DEPTH];
  logic [AW:0]         r_wptr;
  logic [AW:0]         r_rptr;
  logic [HAZ_DIST-1:0] r_hv;
  logic [3:0]          r_hrd [HAZ_DIST];

  logic                r_vld;
  logic [3:0]          r_rs1;
  logic [3:0]          r_rs2;
  logic [3:0]          r_rd;
  logic [3:0]          r_func;
  logic [7:0]          r_addr;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_haz;
  logic        w_issue;
  logic [23:0] w_head;

  // Same index, different wrap bit means the write side lapped the read side.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = in_valid && !w_full && !flush;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i < HAZ_DIST; i++) begin
      if (r_hv[i] && ((r_hrd[i] == w_head[15:12]) ||
                      (r_hrd[i] == w_head[11:8])))
        w_haz = 1'b1;
    end
  end

  assign w_issue = !w_empty && !halt && !flush && !w_haz;

  always_ff @(posedge clk1) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= in_instr;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_issue)
        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // History shifts every edge so hazards age out even while halted.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_hv <= '0;
      for (int i = 0; i < HAZ_DIST; i++)
        r_hrd[i] <= '0;
    end else if (flush) begin
      r_hv <= '0;
    end else begin
      r_hv[0]  <= w_issue;
      r_hrd[0] <= w_head[19:16];
      for (int i = 1; i < HAZ_DIST; i++) begin
        r_hv[i]  <= r_hv[i-1];
        r_hrd[i] <= r_hrd[i-1];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_func <= '0;
      r_addr <= '0;
    end else if (w_issue) begin
      r_vld  <= 1'b1;
      r_func <= w_head[23:20];
      r_rd   <= w_head[19:16];
      r_rs1  <= w_head[15:12];
      r_rs2  <= w_head[11:8];
      r_addr <= w_head[7:0];
    end else begin
      r_vld  <= 1'b0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_func <= '0;
      r_addr <= '0;
    end
  end

  assign in_ready    = !w_full;
  assign issue_valid = r_vld;
  assign rs1         = r_rs1;
  assign rs2         = r_rs2;
  assign rd          = r_rd;
  assign func        = r_func;
  assign addr        = r_addr;

`ifdef PERF_CNT_EN
  logic [15:0] r_icnt;
  logic [15:0] r_scnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_icnt <= '0;
      r_scnt <= '0;
    end else begin
      if (w_issue && (r_icnt != 16'hFFFF))
        r_icnt <= r_icnt + 16'd1;
      if (!w_empty && !halt && !flush && w_haz &&
          (r_scnt != 16'hFFFF))
        r_scnt <= r_scnt + 16'd1;
    end
  end

  assign issue_cnt = r_icnt;
  assign stall_cnt = r_scnt;
`endif

endmodule

// File: tb/tb_pipe_issue.sv
// Scoreboard bench for pipe_issue: directed vectors, queue-based monitor.
// Covers reset, independent issue, RAW bubbles, full, flush, counters.
module tb_pipe_issue;

  logic        clk1;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic        halt;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [3:0]  func;
  logic [7:0]  addr;
`ifdef PERF_CNT_EN
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;
`endif

  pipe_issue dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .halt       (halt),
    .flush      (flush),
    .issue_valid(issue_valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .func       (func),
    .addr       (addr)
`ifdef PERF_CNT_EN
    ,
    .issue_cnt  (issue_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic [23:0] ins;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  bit   sb_off = 0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input int f, input int d,
                                     input int s1, input int s2,
                                     input int a);
    mk = {f[3:0], d[3:0], s1[3:0], s2[3:0], a[7:0]};
  endfunction

  always @(negedge clk1) begin
    exp_t e;
    if (!sb_off) begin
      if (issue_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_issue", {8'h0, func, rd, rs1, rs2, addr},
              32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("issue_fields", {8'h0, func, rd, rs1, rs2, addr},
              {8'h0, e.ins});
          if (e.cyc >= 0)
            chk("issue_cycle", cyc, e.cyc);
        end
      end else begin
        chk("bubble_zero", {8'h0, func, rd, rs1, rs2, addr}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk1);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  logic [23:0] v [5];
  int          n;
  int          c;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    halt     = 1'b0;
    flush    = 1'b0;
    #1;
    chk("rst_valid", {31'h0, issue_valid}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_fields", {8'h0, func, rd, rs1, rs2, addr}, 32'h0);
    #12;
    rst_n = 1'b1;
    tick();

    // Reset mid-operation: A issues, B is lost.
    c = cyc;
    in_valid = 1'b1;
    in_instr = mk(0, 9, 1, 2, 8'h11);
    q.push_back('{mk(0, 9, 1, 2, 8'h11), c + 2});
    tick();
    in_instr = mk(1, 10, 3, 4, 8'h22);
    tick();
    in_valid = 1'b0;
    @(negedge clk1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, issue_valid}, 32'h0);
    chk("midrst_ready", {31'h0, in_ready}, 32'h1);
    chk("midrst_fields", {8'h0, func, rd, rs1, rs2, addr}, 32'h0);
    #2;
    rst_n = 1'b1;
    idle(5);
    chk("midrst_noissue", q.size(), 0);

    // Independent stream at full rate.
    c = cyc;
    in_valid = 1'b1;
    in_instr = mk(0, 10, 3, 5, 8'h40);
    q.push_back('{in_instr, c + 2});
    tick();
    in_instr = mk(2, 12, 3, 8, 8'h41);
    q.push_back('{in_instr, c + 3});
    tick();
    in_instr = mk(11, 13, 7, 3, 8'h42);
    q.push_back('{in_instr, c + 4});
    tick();
    idle(5);
    chk("indep_drain", q.size(), 0);

    // RAW: SUB depends on ADD's rd.
    do_reset();
    c = cyc;
    in_valid = 1'b1;
    in_instr = mk(0, 10, 3, 5, 8'h50);
    q.push_back('{in_instr, c + 2});
    tick();
    in_instr = mk(1, 14, 10, 5, 8'h51);
    q.push_back('{in_instr, c + 5});
    tick();
    idle(6);
    chk("raw_drain", q.size(), 0);
`ifdef PERF_CNT_EN
    chk("perf_issue", {16'h0, issue_cnt}, 32'd2);
    chk("perf_stall", {16'h0, stall_cnt}, 32'd2);
`endif

    // Full FIFO while halted, then drain in order.
    v[0] = mk(0, 8, 1, 2, 8'h60);
    v[1] = mk(1, 9, 2, 3, 8'h61);
    v[2] = mk(2, 10, 3, 1, 8'h62);
    v[3] = mk(3, 11, 1, 1, 8'h63);
    v[4] = mk(4, 12, 2, 2, 8'h64);
    halt = 1'b1;
    for (int i = 0; i < 5; i++)
      q.push_back('{v[i], -1});
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = v[i];
      tick();
    end
    chk("full_ready", {31'h0, in_ready}, 32'h0);
    in_instr = v[4];
    tick();
    tick();
    chk("full_held", {31'h0, in_ready}, 32'h0);
    chk("halt_noissue", q.size(), 5);
    halt = 1'b0;
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    chk("full_timeout", {31'h0, in_ready}, 32'h1);
    tick();
    idle(8);
    chk("full_drain", q.size(), 0);

    // Flush with a same-cycle push.
    halt = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = mk(5, 4 + i, 1, 2, 8'h70 + i);
      tick();
    end
    flush = 1'b1;
    in_instr = mk(6, 7, 1, 2, 8'h7F);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'h0, issue_valid}, 32'h0);
    chk("flush_ready", {31'h0, in_ready}, 32'h1);
    halt = 1'b0;
    idle(6);
    chk("flush_noissue", q.size(), 0);

`ifdef PERF_CNT_EN
    do_reset();
    sb_off = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(0, 1, 0, 0, 8'h00);
    repeat (65540) tick();
    idle(4);
    chk("perf_sat", {16'h0, issue_cnt}, 32'h0000_FFFF);
    chk("perf_sat_stall", {16'h0, stall_cnt}, 32'h0);
    sb_off = 1'b0;
`endif

    idle(2);
    chk("final_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
